// File: rtl/pc_unit.sv
// Program-counter unit: sequential/relative/absolute updates, call/return through a
// circular return-address stack, and alignment-fault blocking of bad targets.
module pc_unit #(
    parameter int unsigned      WIDTH        = 32,
    parameter int unsigned      STEP         = 4,
    parameter int unsigned      ALIGN_BITS   = 2,
    parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
    parameter int unsigned      RAS_DEPTH    = 8,
    localparam int unsigned     CNT_W        = $clog2(RAS_DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             step_pc,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] systembus_in,
    output logic [WIDTH-1:0] systembus_out,
    output logic             misaligned,
    output logic             fault,
    output logic [WIDTH-1:0] fault_addr,
    output logic             bad_op,
    output logic [CNT_W-1:0] ras_count,
    output logic             ras_overflow,
    output logic             ras_underflow
);

    localparam int unsigned      PTR_W  = $clog2(RAS_DEPTH);
    localparam logic [WIDTH-1:0] STEP_W = WIDTH'(STEP);
    localparam logic [CNT_W-1:0] FULL   = CNT_W'(RAS_DEPTH);

    typedef enum logic [2:0] {
        OpInc     = 3'b000,
        OpRel     = 3'b001,
        OpAbs     = 3'b010,
        OpCallRel = 3'b011,
        OpCallAbs = 3'b100,
        OpRet     = 3'b101
    } op_e;

    // Architectural state
    logic [WIDTH-1:0] pc_q, pc_d;
    logic [PTR_W-1:0] ras_ptr_q, ras_ptr_d;
    logic [CNT_W-1:0] ras_count_q, ras_count_d;
    logic [WIDTH-1:0] fault_addr_q, fault_addr_d;
    logic             fault_q, fault_d;
    logic             bad_op_q, bad_op_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;

    // Return-address storage; contents need no reset
    logic [WIDTH-1:0] ras_mem [RAS_DEPTH];

    // Decode / target selection
    op_e              op_dec;
    logic [WIDTH-1:0] target;
    logic [WIDTH-1:0] ret_addr;
    logic [PTR_W-1:0] top_ptr;
    logic             has_target;
    logic             want_push;
    logic             want_pop;
    logic             tgt_misaligned;
    logic             commit;
    logic             do_push;
    logic             do_pop;

    assign op_dec   = op_e'(op);
    assign ret_addr = pc_q + STEP_W;
    // Write pointer names the next free slot, so the top is one below it
    assign top_ptr  = ras_ptr_q - PTR_W'(1);

    always_comb begin
        target     = pc_q;
        has_target = 1'b0;
        want_push  = 1'b0;
        want_pop   = 1'b0;
        bad_op_d   = 1'b0;
        unf_d      = 1'b0;
        if (step_pc) begin
            case (op_dec)
                OpInc: begin
                    target     = pc_q + STEP_W;
                    has_target = 1'b1;
                end
                OpRel: begin
                    target     = pc_q + systembus_in;
                    has_target = 1'b1;
                end
                OpAbs: begin
                    target     = systembus_in;
                    has_target = 1'b1;
                end
                OpCallRel: begin
                    target     = pc_q + systembus_in;
                    has_target = 1'b1;
                    want_push  = 1'b1;
                end
                OpCallAbs: begin
                    target     = systembus_in;
                    has_target = 1'b1;
                    want_push  = 1'b1;
                end
                OpRet: begin
                    // An empty stack yields no target, so it can never also fault
                    if (ras_count_q == '0) begin
                        unf_d = 1'b1;
                    end else begin
                        target     = ras_mem[top_ptr];
                        has_target = 1'b1;
                        want_pop   = 1'b1;
                    end
                end
                default: begin
                    bad_op_d = 1'b1;
                end
            endcase
        end
    end

    assign tgt_misaligned = |target[ALIGN_BITS-1:0];
    assign commit         = has_target && !tgt_misaligned;
    assign do_push        = commit && want_push;
    assign do_pop         = commit && want_pop;

    always_comb begin
        pc_d         = commit ? target : pc_q;
        fault_d      = has_target && tgt_misaligned;
        fault_addr_d = fault_d ? target : fault_addr_q;
        ras_ptr_d    = ras_ptr_q;
        ras_count_d  = ras_count_q;
        ovf_d        = 1'b0;
        if (do_push) begin
            // Full stack: the pointer wraps onto the oldest entry and the count saturates
            ras_ptr_d = ras_ptr_q + PTR_W'(1);
            if (ras_count_q == FULL) begin
                ovf_d = 1'b1;
            end else begin
                ras_count_d = ras_count_q + CNT_W'(1);
            end
        end else if (do_pop) begin
            ras_ptr_d   = top_ptr;
            ras_count_d = ras_count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q         <= RESET_VECTOR;
            ras_ptr_q    <= '0;
            ras_count_q  <= '0;
            fault_addr_q <= '0;
            fault_q      <= 1'b0;
            bad_op_q     <= 1'b0;
            ovf_q        <= 1'b0;
            unf_q        <= 1'b0;
        end else begin
            pc_q         <= pc_d;
            ras_ptr_q    <= ras_ptr_d;
            ras_count_q  <= ras_count_d;
            fault_addr_q <= fault_addr_d;
            fault_q      <= fault_d;
            bad_op_q     <= bad_op_d;
            ovf_q        <= ovf_d;
            unf_q        <= unf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && do_push) begin
            ras_mem[ras_ptr_q] <= ret_addr;
        end
    end

    assign systembus_out = pc_q;
    assign misaligned    = |pc_q[ALIGN_BITS-1:0];
    assign fault         = fault_q;
    assign fault_addr    = fault_addr_q;
    assign bad_op        = bad_op_q;
    assign ras_count     = ras_count_q;
    assign ras_overflow  = ovf_q;
    assign ras_underflow = unf_q;

endmodule

// File: tb/tb_pc_unit.sv
// Self-checking bench for pc_unit: vector table plus overflow/wrap sequence, with
// expected results queued at drive time and compared one cycle later.
module tb_pc_unit;

    localparam logic [2:0] INC = 3'd0, REL = 3'd1, ABS = 3'd2, CREL = 3'd3, CABS = 3'd4,
                           RET = 3'd5;

    typedef struct {
        logic        rst;
        logic        step;
        logic [2:0]  op;
        logic [31:0] bus;
        logic [31:0] pc;
        logic [3:0]  cnt;
        logic        flt;
        logic [31:0] faddr;
        logic        bad;
        logic        ovf;
        logic        unf;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        step_pc = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [31:0] systembus_in = '0;
    logic [31:0] systembus_out;
    logic        misaligned;
    logic        fault;
    logic [31:0] fault_addr;
    logic        bad_op;
    logic [3:0]  ras_count;
    logic        ras_overflow;
    logic        ras_underflow;

    int n_checks = 0;
    int n_fail   = 0;
    vec_t tbl[$];
    vec_t sb[$];

    pc_unit dut (
        .clk          (clk),
        .rst          (rst),
        .step_pc      (step_pc),
        .op           (op),
        .systembus_in (systembus_in),
        .systembus_out(systembus_out),
        .misaligned   (misaligned),
        .fault        (fault),
        .fault_addr   (fault_addr),
        .bad_op       (bad_op),
        .ras_count    (ras_count),
        .ras_overflow (ras_overflow),
        .ras_underflow(ras_underflow)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    function automatic vec_t mk(input logic r, input logic s, input logic [2:0] o,
                                input logic [31:0] b, input logic [31:0] p,
                                input logic [3:0] c, input logic f, input logic [31:0] fa,
                                input logic bo, input logic ov, input logic un);
        vec_t v;
        v.rst = r; v.step = s; v.op = o; v.bus = b; v.pc = p; v.cnt = c;
        v.flt = f; v.faddr = fa; v.bad = bo; v.ovf = ov; v.unf = un;
        return v;
    endfunction

    task automatic check(input string name, input int idx, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s step %0d: got %h, expected %h", name, idx, act, exp);
        end
    endtask

    task automatic compare_next(input int idx);
        vec_t e;
        n_checks++;
        if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL scoreboard step %0d: got empty queue, expected an entry", idx);
        end else begin
            e = sb.pop_front();
            check("pc", idx, systembus_out, e.pc);
            check("ras_count", idx, 32'(ras_count), 32'(e.cnt));
            check("fault", idx, 32'(fault), 32'(e.flt));
            check("fault_addr", idx, fault_addr, e.faddr);
            check("bad_op", idx, 32'(bad_op), 32'(e.bad));
            check("ras_overflow", idx, 32'(ras_overflow), 32'(e.ovf));
            check("ras_underflow", idx, 32'(ras_underflow), 32'(e.unf));
            check("misaligned", idx, 32'(misaligned), 32'(0));
        end
    endtask

    task automatic drive(input vec_t v, input int idx);
        @(negedge clk);
        rst          = v.rst;
        step_pc      = v.step;
        op           = v.op;
        systembus_in = v.bus;
        sb.push_back(v);
        @(posedge clk);
        #1;
        compare_next(idx);
    endtask

    initial begin
        int idx = 0;
        //             rst stp op    bus           pc            cnt flt faddr     bad ovf unf
        tbl.push_back(mk(1, 0, INC,  32'h0,        32'h0,        0, 0, 32'h0,   0, 0, 0));
        tbl.push_back(mk(0, 1, INC,  32'h0,        32'h4,        0, 0, 32'h0,   0, 0, 0));
        tbl.push_back(mk(0, 0, INC,  32'h0,        32'h4,        0, 0, 32'h0,   0, 0, 0));
        tbl.push_back(mk(0, 0, 3'd6, 32'h0,        32'h4,        0, 0, 32'h0,   0, 0, 0));
        tbl.push_back(mk(0, 1, INC,  32'h0,        32'h8,        0, 0, 32'h0,   0, 0, 0));
        tbl.push_back(mk(0, 1, INC,  32'h0,        32'hC,        0, 0, 32'h0,   0, 0, 0));
        tbl.push_back(mk(0, 1, ABS,  32'hFFFFFFF8, 32'hFFFFFFF8, 0, 0, 32'h0,   0, 0, 0));
        tbl.push_back(mk(0, 1, REL,  32'h10,       32'h8,        0, 0, 32'h0,   0, 0, 0));
        tbl.push_back(mk(0, 1, REL,  32'hFFFFFFF8, 32'h0,        0, 0, 32'h0,   0, 0, 0));
        tbl.push_back(mk(0, 1, ABS,  32'h40,       32'h40,       0, 0, 32'h0,   0, 0, 0));
        tbl.push_back(mk(0, 1, CABS, 32'h100,      32'h100,      1, 0, 32'h0,   0, 0, 0));
        tbl.push_back(mk(0, 1, CREL, 32'h20,       32'h120,      2, 0, 32'h0,   0, 0, 0));
        tbl.push_back(mk(0, 1, RET,  32'h0,        32'h104,      1, 0, 32'h0,   0, 0, 0));
        tbl.push_back(mk(0, 1, RET,  32'h0,        32'h44,       0, 0, 32'h0,   0, 0, 0));
        tbl.push_back(mk(0, 1, RET,  32'h0,        32'h44,       0, 0, 32'h0,   0, 0, 1));
        tbl.push_back(mk(0, 1, ABS,  32'h200,      32'h200,      0, 0, 32'h0,   0, 0, 0));
        tbl.push_back(mk(0, 1, ABS,  32'h203,      32'h200,      0, 1, 32'h203, 0, 0, 0));
        tbl.push_back(mk(0, 0, ABS,  32'h203,      32'h200,      0, 0, 32'h203, 0, 0, 0));
        tbl.push_back(mk(0, 1, CABS, 32'h300,      32'h300,      1, 0, 32'h203, 0, 0, 0));
        tbl.push_back(mk(0, 1, CREL, 32'h2,        32'h300,      1, 1, 32'h302, 0, 0, 0));
        tbl.push_back(mk(0, 1, RET,  32'h0,        32'h204,      0, 0, 32'h302, 0, 0, 0));
        tbl.push_back(mk(0, 1, 3'd6, 32'h0,        32'h204,      0, 0, 32'h302, 1, 0, 0));
        tbl.push_back(mk(0, 1, 3'd7, 32'h0,        32'h204,      0, 0, 32'h302, 1, 0, 0));
        tbl.push_back(mk(0, 1, INC,  32'h0,        32'h208,      0, 0, 32'h302, 0, 0, 0));
        tbl.push_back(mk(0, 1, CABS, 32'h500,      32'h500,      1, 0, 32'h302, 0, 0, 0));
        tbl.push_back(mk(1, 1, CABS, 32'h600,      32'h0,        0, 0, 32'h0,   0, 0, 0));
        tbl.push_back(mk(0, 1, RET,  32'h0,        32'h0,        0, 0, 32'h0,   0, 0, 1));

        foreach (tbl[i]) begin
            drive(tbl[i], idx);
            idx++;
        end

        // Overflow and wrap: nine calls of +8 from 0, then nine returns
        drive(mk(1, 0, INC, 32'h0, 32'h0, 0, 0, 32'h0, 0, 0, 0), idx++);
        for (int k = 1; k <= 9; k++) begin
            drive(mk(0, 1, CREL, 32'h8, 32'(8 * k), 4'((k < 8) ? k : 8), 0, 32'h0, 0,
                     (k == 9), 0), idx++);
        end
        for (int j = 0; j < 8; j++) begin
            drive(mk(0, 1, RET, 32'h0, 32'(8 * (8 - j) + 4), 4'(7 - j), 0, 32'h0, 0, 0, 0),
                  idx++);
        end
        drive(mk(0, 1, RET, 32'h0, 32'hC, 0, 0, 32'h0, 0, 0, 1), idx++);
        // Pulses must drop again once stepping stops
        drive(mk(0, 0, RET, 32'h0, 32'hC, 0, 0, 32'h0, 0, 0, 0), idx++);

        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard drain: got %0d entries left, expected 0", sb.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pc_unit.md
# pc_unit

Parametrised program-counter unit; the next generation of the core's PC block. Holds the architectural PC and drives it onto the system bus. Supports sequential increment, relative branch, absolute jump, call/return through an internal return-address stack (RAS), and alignment-fault blocking of bad targets. Sits between the decoder/branch logic (which supplies `op` and the target/offset on `systembus_in`) and instruction fetch.

## Interface
- `WIDTH`, 32: PC and bus width in bits.
- `STEP`, 4: increment added by INC; also the return-address offset.
- `ALIGN_BITS`, 2: number of PC LSBs that must be zero. Must be ≥1.
- `RESET_VECTOR`, 0: PC value after reset. Must be aligned.
- `RAS_DEPTH`, 8: number of return-stack entries. Must be ≥2 and a power of two.
- `clk` in 1: single clock; all state updates on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `step_pc` in 1: advance enable. The op is executed only on an edge where `step_pc`=1.
- `op` in 3: 000 INC, 001 REL, 010 ABS, 011 CALL_REL, 100 CALL_ABS, 101 RET, 110/111 reserved.
- `systembus_in` in WIDTH: branch offset (REL, CALL_REL) or absolute target (ABS, CALL_ABS). Two's-complement for offsets.
- `systembus_out` out WIDTH: current PC (registered).
- `misaligned` out 1: combinational; `systembus_out[ALIGN_BITS-1:0] != 0`.
- `fault` out 1: one-cycle pulse, target misaligned and update blocked.
- `fault_addr` out WIDTH: rejected target from the most recent fault; holds until the next fault.
- `bad_op` out 1: one-cycle pulse, reserved op executed.
- `ras_count` out clog2(RAS_DEPTH+1): valid entries in the RAS.
- `ras_overflow` out 1: one-cycle pulse, push while full.
- `ras_underflow` out 1: one-cycle pulse, RET while empty.

## Operation
- Target computation: all arithmetic is modulo 2^WIDTH; carries out are discarded and never flagged.
  - INC: `pc+STEP`
  - REL / CALL_REL: `pc+systembus_in`
  - ABS / CALL_ABS: `systembus_in`
  - RET: the RAS top entry
- Alignment check:
  - If the computed target has any nonzero bit in `[ALIGN_BITS-1:0]`:
    - PC is unchanged and no RAS push or pop occurs.
    - `fault` pulses and `fault_addr` is loaded with the target.
  - The check applies to every op, including INC and RET.
- CALL_REL / CALL_ABS (target aligned): push `pc+STEP` onto the RAS, then PC = target.
- RET, RAS non-empty: PC = top entry; the entry is popped.
- RET, RAS empty: PC is unchanged and `ras_underflow` pulses. No fault is raised.
- Reserved op: PC and RAS are unchanged and `bad_op` pulses.
- RAS structure: circular buffer, a write pointer plus `ras_count`.
- RAS overflow (push while `ras_count`==RAS_DEPTH):
  - The oldest entry is overwritten (pointer wraps).
  - `ras_count` stays at RAS_DEPTH and `ras_overflow` pulses.
  - The call itself completes normally.
- Pop wrap: a pop after overflow returns the newest entries first. After RAS_DEPTH pops the stack reads as empty; the overwritten entries are lost.
- `step_pc`=0: all state holds and every pulse output is 0 on the next cycle.
- Reset (`rst`=1 at an edge) overrides `step_pc` and `op`:
  - PC = RESET_VECTOR, `ras_count`=0, RAS pointer=0.
  - `fault_addr`=0; `fault`, `bad_op`, `ras_overflow`, `ras_underflow` = 0.
  - RAS entry contents are don't-care.
  - A call or return in flight at that edge is discarded.

## Timing
- Latency: one cycle. An op sampled at edge N is visible on `systembus_out` after edge N.
- All pulse outputs are registered. Each is high for exactly the cycle after the causing edge and 0 otherwise.
- Back-to-back steps are allowed every cycle; there is no stall or handshake.
- CALL then RET on consecutive edges returns to `call_pc+STEP`. This requires a same-cycle bypass-free design: the push is written at edge N and readable at edge N+1.
- `misaligned` is derived only from the PC register, so it can only assert if RESET_VECTOR is misaligned (a configuration error). It is retained for bus compatibility.
- `fault` and `ras_underflow` are mutually exclusive: RET on an empty stack never computes a target.

## Test plan
- Reset then INC ×3 with `step_pc`=1: PC goes 0 → 4 → 8 → 12. With `step_pc`=0 for 2 cycles in between, PC holds and there are no pulses.
- REL wrap, WIDTH=32: PC=0xFFFFFFF8, `systembus_in`=0x10, REL → PC=0x00000008, no fault. Then REL with 0xFFFFFFF8 (−8) → PC=0x00000000.
- CALL_ABS 0x100 from PC=0x40, then CALL_REL +0x20, then RET ×2:
  - PC sequence 0x40 → 0x100 → 0x120 → 0x104 → 0x44.
  - `ras_count` 0 → 1 → 2 → 1 → 0.
  - A third RET gives `ras_underflow`=1 and PC stays 0x44.
- Overflow, RAS_DEPTH=8: 9 successive CALL_REL +8 from PC=0.
  - The 9th call gives `ras_overflow`=1 and `ras_count` stays 8.
  - 8 RETs return 0x44, 0x3C, …, 0x0C.
  - A 9th RET underflows.
- Alignment fault: PC=0x200, ABS 0x203 → `fault`=1, `fault_addr`=0x203, PC stays 0x200. CALL_REL +2 → fault, `ras_count` unchanged.
- Op 110 gives `bad_op` pulse, PC unchanged. `rst` asserted on the same edge as a CALL → PC=RESET_VECTOR, `ras_count`=0, all pulses 0.
